// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined MIPS core.
// Used by the fetch stage, the decode stage and the hazard unit.
package cpu_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;

  // All-zero word decodes as sll $0,$0,0, the architectural NOP
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int unsigned       DEFAULT_PC_STEP  = 4;

  // Instruction fetches are word aligned, so the two low address bits are
  // simply dropped rather than trapped as a misalignment
  function automatic logic [ADDR_W-1:0] wordAlign(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'(3);
  endfunction

endpackage

// File: rtl/fetch_stage_pc_register.sv
// Program counter for the fetch stage.
// Holds the PC, its reset value, and the next-PC priority selection
// (reset, redirect, stall, sequential increment).
module pc_register
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned       PC_STEP  = DEFAULT_PC_STEP
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirectPc_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] pcPlusStep_o
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] pcPlusStep;

  // Sequential address; the add wraps naturally at 2^32 with no carry out
  assign pcPlusStep = pc_q + ADDR_W'(PC_STEP);

  // A resolved branch beats a stall: the stalled younger fetch is wrong-path
  // anyway, so there is nothing worth holding the PC for
  always_comb begin
    pc_d = pcPlusStep;
    if (redirect_i) begin
      pc_d = wordAlign(redirectPc_i);
    end else if (stall_i) begin
      pc_d = pc_q;
    end
  end

  // PC register with synchronous reset taking priority over everything
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o         = pc_q;
  assign pcPlusStep_o = pcPlusStep;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the 5-stage MIPS pipeline.
// Drives the instruction-memory address from the PC, and captures the fetched
// word plus its return address into the IF/ID pipeline register.
// Build option: define DELAY_SLOT_EN to keep the branch delay-slot instruction
// on a redirect instead of squashing it. Port list is the same either way.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned       PC_STEP  = DEFAULT_PC_STEP
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Stall,
  input  logic               Redirect,
  input  logic [ADDR_W-1:0]  RedirectPC,
  input  logic               Flush,
  input  logic [INSTR_W-1:0] ImemData,
  output logic [ADDR_W-1:0]  ImemAddr,
  output logic [ADDR_W-1:0]  PC,
  output logic [INSTR_W-1:0] IFID_Instruction,
  output logic [ADDR_W-1:0]  IFID_PCPlus4,
  output logic               IFID_Valid
);

  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  pcPlusStep;

  logic [INSTR_W-1:0] instr_q;
  logic [INSTR_W-1:0] instr_d;
  logic [ADDR_W-1:0]  pcPlus4_q;
  logic [ADDR_W-1:0]  pcPlus4_d;
  logic               valid_q;
  logic               valid_d;

  pc_register #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pcRegister (
    .clk_i        (Clk),
    .reset_i      (Reset),
    .stall_i      (Stall),
    .redirect_i   (Redirect),
    .redirectPc_i (RedirectPC),
    .pc_o         (pc),
    .pcPlusStep_o (pcPlusStep)
  );

  // IF/ID next state: flush, then redirect handling, then stall, then load the
  // word that memory is returning for the current PC this cycle
  always_comb begin
    instr_d   = instr_q;
    pcPlus4_d = pcPlus4_q;
    valid_d   = valid_q;
    if (Flush) begin
      instr_d   = NOP_INSTR;
      pcPlus4_d = '0;
      valid_d   = 1'b0;
    end else if (Redirect) begin
`ifdef DELAY_SLOT_EN
      // The word after the branch is the architectural delay slot and must
      // execute, even if the hazard unit asked for a stall this cycle
      instr_d   = ImemData;
      pcPlus4_d = pcPlusStep;
      valid_d   = 1'b1;
`else
      // No delay slot: the word being fetched is wrong-path, turn it into a bubble
      instr_d   = NOP_INSTR;
      pcPlus4_d = '0;
      valid_d   = 1'b0;
`endif
    end else if (!Stall) begin
      instr_d   = ImemData;
      pcPlus4_d = pcPlusStep;
      valid_d   = 1'b1;
    end
  end

  // IF/ID pipeline register; reset leaves a bubble holding a NOP
  always_ff @(posedge Clk) begin
    if (Reset) begin
      instr_q   <= NOP_INSTR;
      pcPlus4_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      instr_q   <= instr_d;
      pcPlus4_q <= pcPlus4_d;
      valid_q   <= valid_d;
    end
  end

  assign ImemAddr         = pc;
  assign PC               = pc;
  assign IFID_Instruction = instr_q;
  assign IFID_PCPlus4     = pcPlus4_q;
  assign IFID_Valid       = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage.
// Table of per-cycle input vectors with hand-computed register contents after
// each rising edge, followed by a short hand-written multi-cycle stall sequence.
module tb_fetch_stage;

`ifdef DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirectPc;
  logic        flush;
  logic [31:0] imemData;
  logic [31:0] imemAddr;
  logic [31:0] pc;
  logic [31:0] ifidInstruction;
  logic [31:0] ifidPcPlus4;
  logic        ifidValid;

  int checkCount = 0;
  int errorCount = 0;

  typedef struct {
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirectPc;
    logic        flush;
    logic [31:0] expPc;
    logic [31:0] expInstr;
    logic [31:0] expPcPlus4;
    logic        expValid;
  } vec_t;

  vec_t vecs[$];

  fetch_stage dut (
    .Clk              (clk),
    .Reset            (reset),
    .Stall            (stall),
    .Redirect         (redirect),
    .RedirectPC       (redirectPc),
    .Flush            (flush),
    .ImemData         (imemData),
    .ImemAddr         (imemAddr),
    .PC               (pc),
    .IFID_Instruction (ifidInstruction),
    .IFID_PCPlus4     (ifidPcPlus4),
    .IFID_Valid       (ifidValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: one known ADDI at 0, elsewhere a word tagged with its address
  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return (addr == 32'h0) ? 32'h2008_0005 : (32'hC000_0000 | addr);
  endfunction

  assign imemData = memWord(imemAddr);

  function automatic vec_t mk(input logic r, input logic s, input logic rd,
                              input logic [31:0] rpc, input logic f,
                              input logic [31:0] ePc, input logic [31:0] eIns,
                              input logic [31:0] eP4, input logic eV);
    vec_t v;
    v.reset = r; v.stall = s; v.redirect = rd; v.redirectPc = rpc; v.flush = f;
    v.expPc = ePc; v.expInstr = eIns; v.expPcPlus4 = eP4; v.expValid = eV;
    return v;
  endfunction

  // Expected IF/ID after a redirect at fetch address 'at' (with no flush)
  function automatic vec_t mkRedir(input logic s, input logic [31:0] rpc,
                                   input logic [31:0] ePc, input logic [31:0] at);
    if (DS) return mk(0, s, 1, rpc, 0, ePc, memWord(at), at + 32'd4, 1'b1);
    return mk(0, s, 1, rpc, 0, ePc, 32'h0, 32'h0, 1'b0);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic rd,
                               input logic [31:0] rpc, input logic f);
    reset = r; stall = s; redirect = rd; redirectPc = rpc; flush = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirectPc = 32'h0; flush = 1'b0;

    //                 rst stl rd  rpc            fl  pc             instr          pc+4           v
    vecs.push_back(mk(1, 0, 0, 32'h0,          0, 32'h0,         32'h0,         32'h0,         0));
    vecs.push_back(mk(0, 0, 0, 32'h0,          0, 32'h4,         32'h2008_0005, 32'h4,         1));
    vecs.push_back(mk(0, 0, 0, 32'h0,          0, 32'h8,         32'hC000_0004, 32'h8,         1));
    vecs.push_back(mk(0, 1, 0, 32'h0,          0, 32'h8,         32'hC000_0004, 32'h8,         1));
    vecs.push_back(mk(0, 1, 0, 32'h0,          0, 32'h8,         32'hC000_0004, 32'h8,         1));
    vecs.push_back(mk(0, 0, 0, 32'h0,          0, 32'hC,         32'hC000_0008, 32'hC,         1));
    vecs.push_back(mkRedir(0, 32'h40,  32'h40,  32'hC));
    vecs.push_back(mk(0, 0, 0, 32'h0,          0, 32'h44,        32'hC000_0040, 32'h44,        1));
    vecs.push_back(mkRedir(1, 32'h80,  32'h80,  32'h44));
    vecs.push_back(mk(0, 1, 0, 32'h0,          1, 32'h80,        32'h0,         32'h0,         0));
    vecs.push_back(mk(0, 0, 0, 32'h0,          0, 32'h84,        32'hC000_0080, 32'h84,        1));
    vecs.push_back(mkRedir(0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h84));
    vecs.push_back(mk(0, 0, 0, 32'h0,          0, 32'h0,         32'hFFFF_FFFC, 32'h0,         1));
    vecs.push_back(mkRedir(0, 32'h43,  32'h40,  32'h0));
    vecs.push_back(mkRedir(0, 32'h100, 32'h100, 32'h40));
    vecs.push_back(mkRedir(0, 32'h200, 32'h200, 32'h100));
    vecs.push_back(mk(0, 0, 0, 32'h0,          0, 32'h204,       32'hC000_0200, 32'h204,       1));
    vecs.push_back(mkRedir(0, 32'h40,  32'h40,  32'h204));
    vecs.push_back(mk(1, 0, 1, 32'h80,         0, 32'h0,         32'h0,         32'h0,         0));
    vecs.push_back(mk(0, 0, 0, 32'h0,          0, 32'h4,         32'h2008_0005, 32'h4,         1));
    vecs.push_back(mk(0, 0, 1, 32'h300,        1, 32'h300,       32'h0,         32'h0,         0));
    vecs.push_back(mk(0, 0, 0, 32'h0,          1, 32'h304,       32'h0,         32'h0,         0));
    vecs.push_back(mk(1, 1, 0, 32'h0,          0, 32'h0,         32'h0,         32'h0,         0));

    $display("[TB] applying %0d vectors (delay slot %0d)", vecs.size(), DS);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].reset, vecs[i].stall, vecs[i].redirect,
                    vecs[i].redirectPc, vecs[i].flush);
      checkOutput($sformatf("v%0d.PC", i), pc, vecs[i].expPc);
      checkOutput($sformatf("v%0d.ImemAddr", i), imemAddr, vecs[i].expPc);
      checkOutput($sformatf("v%0d.Instr", i), ifidInstruction, vecs[i].expInstr);
      checkOutput($sformatf("v%0d.PCPlus4", i), ifidPcPlus4, vecs[i].expPcPlus4);
      checkOutput($sformatf("v%0d.Valid", i), {31'h0, ifidValid}, {31'h0, vecs[i].expValid});
    end

    // Hand sequence: one fetch out of reset, then a three-cycle stall must
    // freeze both the PC and the captured word, and release steps once
    applyStimulus(0, 0, 0, 32'h0, 0);
    checkOutput("seq.pcAfterFetch", pc, 32'h4);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 1, 0, 32'h0, 0);
      checkOutput($sformatf("seq.stall%0d.PC", k), pc, 32'h4);
      checkOutput($sformatf("seq.stall%0d.Instr", k), ifidInstruction, 32'h2008_0005);
      checkOutput($sformatf("seq.stall%0d.Valid", k), {31'h0, ifidValid}, 32'h1);
    end
    applyStimulus(0, 0, 0, 32'h0, 0);
    checkOutput("seq.release.PC", pc, 32'h8);
    checkOutput("seq.release.Instr", ifidInstruction, 32'hC000_0004);
    checkOutput("seq.release.PCPlus4", ifidPcPlus4, 32'h8);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined MIPS core, sitting directly upstream of decode inside the top-level head module.
- Owns the program counter and drives the external instruction-memory address.
- Captures each fetched word into the IF/ID pipeline register.
- Accepts stall requests from the hazard unit and branch/jump redirects from decode.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, byte increment per sequential fetch.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Stall  input  1  hazard unit hold: freeze PC and IF/ID.
- Redirect  input  1  taken branch/jump resolved in decode.
- RedirectPC  input  32  target address; valid when Redirect=1.
- Flush  input  1  squash IF/ID contents (exception or hazard kill).
- ImemData  input  32  instruction word, combinational read of ImemAddr.
- ImemAddr  output  32  current fetch address, equal to PC.
- PC  output  32  current program counter (exported to head's PC port).
- IFID_Instruction  output  32  latched instruction.
- IFID_PCPlus4  output  32  latched PC+PC_STEP of that instruction.
- IFID_Valid  output  1  IF/ID holds a real instruction (0 = bubble).

Behaviour:
- Reset (sampled at the clock edge):
  - PC=RESET_PC, IFID_Instruction=32'h0 (NOP, sll $0,$0,0), IFID_PCPlus4=0, IFID_Valid=0.
  - Reset overrides every other input, including mid-redirect or mid-stall.
- Fetch is combinational: ImemAddr=PC in the same cycle, and ImemData is consumed in that cycle. Latency is one cycle from PC to IF/ID.
- PC next-state priority, highest first:
  - Reset: RESET_PC.
  - Redirect: RedirectPC.
  - Stall: hold.
  - Otherwise: PC+PC_STEP.
- PC addition wraps modulo 2^32. 32'hFFFF_FFFC+4 gives 0, with no flag.
- RedirectPC[1:0] is ignored: it is forced to 2'b00 on load. Misalignment is not trapped.
- IF/ID next-state priority, highest first:
  - Reset.
  - Flush: load NOP, Valid=0.
  - Redirect: see Optional Feature.
  - Stall: hold all three fields.
  - Otherwise: load ImemData, PC+PC_STEP, Valid=1.
- Redirect and Stall together: redirect wins for PC, because the branch is resolved and the stalled younger fetch is discarded.
- Flush and Stall together: flush wins. IF/ID becomes a bubble while the PC still holds.
- Two or more consecutive Redirect cycles: each one reloads PC, and the last target is the one that wins.
- No internal state machine beyond the PC and IF/ID registers. Valid distinguishes bubbles from real NOPs for downstream stages.

Optional Feature:
- Macro: DELAY_SLOT_EN.
- Defined (MIPS architectural delay slot):
  - On Redirect without Flush, IF/ID loads the instruction currently being fetched (ImemData at PC) with Valid=1.
  - PC loads RedirectPC.
  - Stall is ignored for IF/ID in that cycle.
- Undefined:
  - On Redirect, IF/ID loads NOP with Valid=0, squashing the wrong-path fetch.
  - PC loads RedirectPC.
- Compiled-in and compiled-out builds must have identical port lists.

Decomposition:
- Shared package cpu_pkg holds:
  - INSTR_W=32 and ADDR_W=32.
  - NOP_INSTR=32'h0000_0000.
  - DEFAULT_RESET_PC.
- cpu_pkg is also used by the decode and hazard units.
- One sub-module, pc_register: owns PC, the reset value, and the next-PC priority mux.
- The IF/ID register stays in fetch_stage.

Test Plan:
- Reset, then 4 free-running cycles with memory returning 32'h2008_0005 at address 0 -> PC sequence 0,4,8,12. Cycle 1 shows IFID_Instruction=32'h2008_0005, IFID_PCPlus4=4, Valid=1.
- Stall=1 for 2 cycles at PC=8 -> PC stays 8 and IF/ID is unchanged for both cycles. Release -> PC=12 next cycle.
- Redirect=1 with RedirectPC=32'h40 at PC=12:
  - Next PC=32'h40.
  - Without DELAY_SLOT_EN: Valid=0 and Instruction=0.
  - With DELAY_SLOT_EN: IF/ID holds the word at 12 with Valid=1.
- Redirect=1 and Stall=1 together with RedirectPC=32'h80 -> PC=32'h80 (redirect wins). Flush=1 and Stall=1 -> Valid=0 and PC held.
- PC at 32'hFFFF_FFFC, no stall -> next PC=0. RedirectPC=32'h43 -> PC=32'h40.
- Reset asserted mid-run at PC=32'h40 while Redirect=1 -> next edge gives PC=RESET_PC and Valid=0. Deassert -> PC=4 one cycle later.
